// File: rtl/traffic_seq.sv
// traffic_seq -- traffic-light phase sequencer.
//
// Steps a GREEN -> YELLOW -> RED cycle in auto mode, and also provides
// flashing yellow, forced red and pause modes, all selected by sw.
// Every output is registered.
//
// Optional build macro: SW_SYNC_EN
//   defined   -> sw passes through a two-flop synchronizer (reset to 2'b00)
//                before the sequencer sees it. This adds two cycles of
//                mode-change latency.
//   undefined -> sw is used directly. There is no synchronizer.
//
// Parameters (each is a phase length in clk cycles, legal range 1..15)
//   G_TIME      green phase length
//   Y_TIME      yellow phase length
//   R_TIME      red phase length
//   FLASH_TIME  flashing-yellow half-period
//
// Ports
//   clk            single clock; all state updates on its rising edge
//   rst            asynchronous, active-high reset (forces RED, full R_TIME)
//   sw[1:0]        mode: 00 auto, 01 flash yellow, 10 force red, 11 pause
//   control_r_out  red lamp command
//   control_y_out  yellow lamp command
//   control_g_out  green lamp command
//   remain[3:0]    cycles left in the current phase minus one
//   phase_start    one-cycle pulse in the first cycle of each new state
module traffic_seq #(
  parameter int G_TIME     = 8,
  parameter int Y_TIME     = 3,
  parameter int R_TIME     = 6,
  parameter int FLASH_TIME = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  output logic       control_r_out,
  output logic       control_y_out,
  output logic       control_g_out,
  output logic [3:0] remain,
  output logic       phase_start
);

  typedef enum logic [2:0] {
    GREEN     = 3'd0,
    YELLOW    = 3'd1,
    RED       = 3'd2,
    FLASH_ON  = 3'd3,
    FLASH_OFF = 3'd4,
    FORCE_RED = 3'd5
  } state_t;

  // Mode encodings of sw.
  localparam logic [1:0] SW_AUTO  = 2'b00;
  localparam logic [1:0] SW_FLASH = 2'b01;
  localparam logic [1:0] SW_FORCE = 2'b10;
  localparam logic [1:0] SW_PAUSE = 2'b11;

  // The counter is loaded with the phase length minus one, so a phase lasts
  // exactly <phase>_TIME cycles including the cycle in which it loads.
  localparam logic [3:0] G_LOAD     = 4'(G_TIME - 1);
  localparam logic [3:0] Y_LOAD     = 4'(Y_TIME - 1);
  localparam logic [3:0] R_LOAD     = 4'(R_TIME - 1);
  localparam logic [3:0] FLASH_LOAD = 4'(FLASH_TIME - 1);

  // Lamp pattern {r, y, g} for each state. At most one bit is ever set.
  // An unknown state falls back to red, which is the safe aspect.
  function automatic logic [2:0] lamp_decode(input state_t s);
    logic [2:0] l;
    case (s)
      GREEN:     l = 3'b001;
      YELLOW:    l = 3'b010;
      FLASH_ON:  l = 3'b010;
      RED:       l = 3'b100;
      FORCE_RED: l = 3'b100;
      FLASH_OFF: l = 3'b000;
      default:   l = 3'b100;
    endcase
    return l;
  endfunction

  state_t     state_r;
  logic [3:0] cnt_r;
  logic [2:0] lamp_r;
  logic       phase_start_r;

  state_t     nxt_state_s;
  logic [3:0] nxt_cnt_s;
  logic       nxt_start_s;
  logic [1:0] sw_use_s;

`ifdef SW_SYNC_EN
  logic [1:0] sw_meta_r;
  logic [1:0] sw_sync_r;

  // Two-flop synchronizer that brings sw into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_r <= 2'b00;
      sw_sync_r <= 2'b00;
    end else begin
      sw_meta_r <= sw;
      sw_sync_r <= sw_meta_r;
    end
  end

  assign sw_use_s = sw_sync_r;
`else
  assign sw_use_s = sw;
`endif

  // Next-state, counter and phase-start decode for the sequencer.
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    nxt_start_s = 1'b0;
    case (sw_use_s)
      SW_PAUSE: begin
        // Everything is frozen. Leaving pause resumes from the held values.
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r;
        nxt_start_s = 1'b0;
      end
      SW_FORCE: begin
        if (state_r != FORCE_RED) begin
          nxt_state_s = FORCE_RED;
          nxt_cnt_s   = 4'd0;
          nxt_start_s = 1'b1;
        end else begin
          // Holding in forced red: the counter is pinned at zero.
          nxt_state_s = FORCE_RED;
          nxt_cnt_s   = 4'd0;
          nxt_start_s = 1'b0;
        end
      end
      SW_FLASH: begin
        case (state_r)
          FLASH_ON, FLASH_OFF: begin
            if (cnt_r == 4'd0) begin
              nxt_state_s = (state_r == FLASH_ON) ? FLASH_OFF : FLASH_ON;
              nxt_cnt_s   = FLASH_LOAD;
              nxt_start_s = 1'b1;
            end else begin
              nxt_cnt_s   = cnt_r - 4'd1;
              nxt_start_s = 1'b0;
            end
          end
          default: begin
            // Any auto state or forced red enters flashing with the lamp on.
            nxt_state_s = FLASH_ON;
            nxt_cnt_s   = FLASH_LOAD;
            nxt_start_s = 1'b1;
          end
        endcase
      end
      SW_AUTO: begin
        case (state_r)
          GREEN: begin
            if (cnt_r == 4'd0) begin
              nxt_state_s = YELLOW;
              nxt_cnt_s   = Y_LOAD;
              nxt_start_s = 1'b1;
            end else begin
              nxt_cnt_s   = cnt_r - 4'd1;
              nxt_start_s = 1'b0;
            end
          end
          YELLOW: begin
            if (cnt_r == 4'd0) begin
              nxt_state_s = RED;
              nxt_cnt_s   = R_LOAD;
              nxt_start_s = 1'b1;
            end else begin
              nxt_cnt_s   = cnt_r - 4'd1;
              nxt_start_s = 1'b0;
            end
          end
          RED: begin
            if (cnt_r == 4'd0) begin
              nxt_state_s = GREEN;
              nxt_cnt_s   = G_LOAD;
              nxt_start_s = 1'b1;
            end else begin
              nxt_cnt_s   = cnt_r - 4'd1;
              nxt_start_s = 1'b0;
            end
          end
          default: begin
            // Returning to auto from flash or forced red always goes
            // through a full red phase.
            nxt_state_s = RED;
            nxt_cnt_s   = R_LOAD;
            nxt_start_s = 1'b1;
          end
        endcase
      end
      default: begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r;
        nxt_start_s = 1'b0;
      end
    endcase
  end

  // Sequencer state register. Lamps are decoded from the next state, so
  // they change on the same edge as the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= RED;
      cnt_r         <= R_LOAD;
      lamp_r        <= 3'b100;
      phase_start_r <= 1'b0;
    end else begin
      state_r       <= nxt_state_s;
      cnt_r         <= nxt_cnt_s;
      lamp_r        <= lamp_decode(nxt_state_s);
      phase_start_r <= nxt_start_s;
    end
  end

  assign control_r_out = lamp_r[2];
  assign control_y_out = lamp_r[1];
  assign control_g_out = lamp_r[0];
  assign remain        = cnt_r;
  assign phase_start   = phase_start_r;

endmodule

// File: doc/traffic_seq.md
TRAFFIC_SEQ -- requirements
Module: traffic_seq

Interface
REQ-001 Parameter G_TIME, default 8: green phase length in clk cycles, legal 1..15.
REQ-002 Parameter Y_TIME, default 3: yellow phase length in clk cycles, legal 1..15.
REQ-003 Parameter R_TIME, default 6: red phase length in clk cycles, legal 1..15.
REQ-004 Parameter FLASH_TIME, default 2: flashing-yellow half-period in clk cycles, legal 1..15.
REQ-005 clk  input  1  single clock (the divided clock in the system); all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 sw  input  2  mode select: 00 auto cycle, 01 flash yellow, 10 force red, 11 pause.
REQ-008 control_r_out  output  1  red lamp command.
REQ-009 control_y_out  output  1  yellow lamp command.
REQ-010 control_g_out  output  1  green lamp command.
REQ-011 remain  output  4  cycles left in the current phase minus one; drives led[3:0] downstream.
REQ-012 phase_start  output  1  one-cycle pulse in the first cycle of each newly entered state.

Function
REQ-013 States: GREEN, YELLOW, RED, FLASH_ON, FLASH_OFF, FORCE_RED; all outputs registered.
REQ-014 Lamp encoding: GREEN g=1; YELLOW and FLASH_ON y=1; RED and FORCE_RED r=1; FLASH_OFF all 0; never more than one lamp high.
REQ-015 A 4-bit down-counter loads <phase>_TIME-1 on state entry and decrements by 1 each cycle; remain equals this counter.
REQ-016 sw=00, counter=0: GREEN->YELLOW->RED->GREEN on the next edge; each phase lasts exactly its _TIME cycles.
REQ-017 sw=00 while in FLASH_ON, FLASH_OFF or FORCE_RED: enter RED with counter R_TIME-1 on the next edge.
REQ-018 sw=01 from any auto state or FORCE_RED: enter FLASH_ON on the next edge; FLASH_ON<->FLASH_OFF alternate each FLASH_TIME cycles.
REQ-019 sw=10 from any state: enter FORCE_RED on the next edge; remain=0 and held while sw=10.
REQ-020 sw=11: hold state, counter and lamps unchanged; phase_start=0; leaving 11 resumes from the held state and counter, as if sw had not been 11.
REQ-021 sw sampled every edge; a mode change is visible on outputs one edge after sw is sampled (no extra latency without SW_SYNC_EN).
REQ-022 Re-selecting the current mode (e.g. sw=01 while flashing) does not restart the counter.
REQ-023 phase_start asserts on every state entry including FLASH_ON<->FLASH_OFF toggles; never during pause or FORCE_RED hold.
REQ-024 Counter never wraps: it is reloaded at 0 on transition, or held at 0 in FORCE_RED.

Reset
REQ-025 rst=1 asynchronously forces state RED, counter=R_TIME-1, control_r_out=1, control_y_out=0, control_g_out=0, phase_start=0, regardless of sw.
REQ-026 Reset asserted mid-phase aborts the phase immediately; after deassertion, operation restarts from RED with the full R_TIME.

Configuration
REQ-027 Macro SW_SYNC_EN defined: sw passes through a two-flop synchronizer (reset to 00) before use, adding 2 cycles to mode-change latency (3 edges total).
REQ-028 SW_SYNC_EN undefined: sw is used directly; the synchronizer is absent; latency per REQ-021.

Verification
REQ-029 Reset, sw=00, defaults -> r for 6 cycles (remain 5..0), g for 8, y for 3, r again; phase_start pulses at each entry.
REQ-030 sw=00, switch to 01 mid-green (remain=4) -> next edge y=1, remain=1; y toggles every 2 cycles; back to 00 -> RED with remain=5.
REQ-031 sw=11 in YELLOW at remain=2 for 10 cycles -> outputs frozen, no phase_start; sw=00 -> remain 1, 0, then RED.
REQ-032 sw=10 from GREEN -> next edge r=1, remain=0, held 20 cycles; sw=00 -> RED with remain=5, then GREEN.
REQ-033 rst pulse mid-GREEN (not edge-aligned) -> r=1 immediately; after release, full 6-cycle RED.
REQ-034 SW_SYNC_EN defined, sw 00->10 -> lamps change on the 3rd edge after the change, not earlier.
